// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between pipeline writeback and a 2-deep multi-cycle write queue
module regfile_wr_arbiter #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [A_WIDTH-1:0]    pipe_rd,
  input  logic [D_WIDTH-1:0]    pipe_wd,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [A_WIDTH-1:0]    mc_rd,
  input  logic [D_WIDTH-1:0]    mc_wd,
  output logic                  we3,
  output logic [A_WIDTH-1:0]    a3,
  output logic [D_WIDTH-1:0]    wd3,
  output logic                  pipe_stall,
  output logic [2**A_WIDTH-1:0] pending_mask
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [A_WIDTH-1:0] r_rd [2];
  logic [D_WIDTH-1:0] r_wd [2];
  logic               r_wp, r_rp;
  logic [1:0]         r_cnt;
  logic [SW-1:0]      r_starve;
  logic               w_pipe_act, w_force, w_fifo_gnt, w_pipe_gnt, w_enq;
  assign w_pipe_act = pipe_we & (pipe_rd != '0);
  assign w_force    = (r_cnt != 2'd0) & (r_starve == SW'(STARVE_MAX));
  assign w_fifo_gnt = ~rst & (r_cnt != 2'd0) & (w_force | ~w_pipe_act);
  assign w_pipe_gnt = ~rst & w_pipe_act & ~w_force;
  assign mc_ready   = (r_cnt != 2'd2) & ~rst;
  assign w_enq      = mc_valid & mc_ready & (mc_rd != '0);
  assign we3        = w_fifo_gnt | w_pipe_gnt;
  assign a3         = w_fifo_gnt ? r_rd[r_rp] : w_pipe_gnt ? pipe_rd : '0;
  assign wd3        = w_fifo_gnt ? r_wd[r_rp] : w_pipe_gnt ? pipe_wd : '0;
  assign pipe_stall = ~rst & w_force & w_pipe_act;
  // queue pointers, occupancy and starvation counter; an entry stays queued through its own write cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_starve <= '0;
    end else begin
      if (w_enq) begin
        r_rd[r_wp] <= mc_rd;
        r_wd[r_wp] <= mc_wd;
        r_wp       <= ~r_wp;
      end
      if (w_fifo_gnt) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, w_fifo_gnt};
      if (r_cnt == 2'd0 || w_fifo_gnt) r_starve <= '0;
      else if (r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
    end
  end
  // decode destination registers of all valid queue entries for the hazard unit
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 2; i++)
      if (!rst && (r_cnt == 2'd2 || (r_cnt == 2'd1 && r_rp == i[0]))) pending_mask[r_rd[i]] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random checks of the write-port arbiter against a queue-based model
module tb_regfile_wr_arbiter;
  localparam int AW = 5, DW = 32, SM = 4, N = 32;
  logic clk = 0, rst;
  logic pipe_we, mc_valid, mc_ready, we3, pipe_stall;
  logic [AW-1:0] pipe_rd, mc_rd, a3;
  logic [DW-1:0] pipe_wd, mc_wd, wd3;
  logic [N-1:0] pending_mask;
  always #5 clk = ~clk;
  regfile_wr_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_wd(mc_wd),
    .we3(we3), .a3(a3), .wd3(wd3), .pipe_stall(pipe_stall), .pending_mask(pending_mask));
  typedef struct {logic [AW-1:0] rd; logic [DW-1:0] wd;} ent_t;
  ent_t q[$];
  int m_starve = 0;
  int checks = 0, fails = 0;
  bit chk_en = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void model_grant(output bit fg, output bit pg);
    bit pa, frc;
    pa  = pipe_we && pipe_rd != 0;
    frc = q.size() > 0 && m_starve == SM;
    fg  = !rst && q.size() > 0 && (frc || !pa);
    pg  = !rst && pa && !frc;
  endfunction
  always @(negedge clk) if (chk_en) begin
    bit fg, pg;
    logic [N-1:0] m;
    model_grant(fg, pg);
    m = '0;
    if (!rst) foreach (q[i]) m[q[i].rd] = 1'b1;
    chk("m_ready", 64'(mc_ready), 64'(!rst && q.size() < 2));
    chk("m_we3", 64'(we3), 64'(fg || pg));
    chk("m_a3", 64'(a3), fg ? 64'(q[0].rd) : pg ? 64'(pipe_rd) : 64'd0);
    chk("m_wd3", 64'(wd3), fg ? 64'(q[0].wd) : pg ? 64'(pipe_wd) : 64'd0);
    chk("m_stall", 64'(pipe_stall), 64'(!rst && pipe_we && pipe_rd != 0 && q.size() > 0 && m_starve == SM));
    chk("m_mask", 64'(pending_mask), 64'(m));
  end
  always @(posedge clk) begin
    bit fg, pg, acc;
    model_grant(fg, pg);
    if (rst) begin
      q.delete();
      m_starve = 0;
    end else begin
      acc = mc_valid && q.size() < 2 && mc_rd != 0;
      m_starve = (q.size() == 0 || fg) ? 0 : (m_starve < SM ? m_starve + 1 : SM);
      if (fg) void'(q.pop_front());
      if (acc) q.push_back('{mc_rd, mc_wd});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pipe(bit we, logic [AW-1:0] rd, logic [DW-1:0] wd);
    pipe_we = we; pipe_rd = rd; pipe_wd = wd;
  endtask
  task automatic mc(bit v, logic [AW-1:0] rd, logic [DW-1:0] wd);
    mc_valid = v; mc_rd = rd; mc_wd = wd;
  endtask
  initial begin
    rst = 1; pipe(0, 0, 0); mc(1, 4, 32'h44);
    repeat (2) begin
      tick(); chk_en = 1; #1;
      chk("rst_ready", 64'(mc_ready), 0);
      chk("rst_we3", 64'(we3), 0);
      chk("rst_mask", 64'(pending_mask), 0);
    end
    tick(); rst = 0; mc(0, 0, 0); #1;
    chk("rel_ready", 64'(mc_ready), 1);
    chk("rel_mask", 64'(pending_mask), 0);
    mc(1, 5, 32'hDEADBEEF);
    tick(); mc(0, 0, 0); #1;
    chk("idle_we3", 64'(we3), 1);
    chk("idle_a3", 64'(a3), 5);
    chk("idle_wd3", 64'(wd3), 64'hDEADBEEF);
    chk("idle_mask", 64'(pending_mask), 64'h20);
    tick(); #1;
    chk("idle_we3_off", 64'(we3), 0);
    chk("idle_mask_off", 64'(pending_mask), 0);
    mc(1, 7, 32'h77);
    tick(); mc(0, 0, 0); pipe(1, 3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("prio_a3", 64'(a3), 3);
      chk("prio_stall", 64'(pipe_stall), 0);
      tick();
    end
    #1;
    chk("force_a3", 64'(a3), 7);
    chk("force_wd3", 64'(wd3), 64'h77);
    chk("force_stall", 64'(pipe_stall), 1);
    tick(); #1;
    chk("after_a3", 64'(a3), 3);
    chk("after_stall", 64'(pipe_stall), 0);
    chk("after_mask", 64'(pending_mask), 0);
    mc(1, 1, 32'h11);
    tick(); mc(1, 2, 32'h22);
    tick(); mc(1, 8, 32'h88); #1;
    chk("full_ready", 64'(mc_ready), 0);
    chk("full_mask", 64'(pending_mask), 64'h6);
    tick(); mc(0, 0, 0); pipe(0, 0, 0); #1;
    chk("drain1_a3", 64'(a3), 1);
    tick(); #1;
    chk("drain2_a3", 64'(a3), 2);
    chk("drain2_wd3", 64'(wd3), 64'h22);
    tick(); #1;
    chk("drain_done", 64'(we3), 0);
    mc(1, 9, 32'h99);
    tick(); mc(0, 0, 0); pipe(1, 0, 32'hBAD); #1;
    chk("x0_a3", 64'(a3), 9);
    chk("x0_stall", 64'(pipe_stall), 0);
    tick(); pipe(0, 0, 0); mc(1, 0, 32'h55); #1;
    chk("x0_ready", 64'(mc_ready), 1);
    tick(); mc(0, 0, 0); #1;
    chk("x0_nowrite", 64'(we3), 0);
    chk("x0_mask", 64'(pending_mask), 0);
    mc(1, 10, 32'hA);
    tick(); mc(1, 11, 32'hB); #1;
    chk("sim_a3", 64'(a3), 10);
    tick(); mc(0, 0, 0); #1;
    chk("sim_a3_next", 64'(a3), 11);
    chk("sim_wd3_next", 64'(wd3), 64'hB);
    chk("sim_mask", 64'(pending_mask), 64'h800);
    tick(); pipe(1, 3, 32'h33); mc(1, 12, 32'hC);
    tick(); mc(1, 13, 32'hD);
    tick(); mc(0, 0, 0); rst = 1; #1;
    chk("rstq_we3", 64'(we3), 0);
    chk("rstq_mask", 64'(pending_mask), 0);
    tick(); rst = 0; pipe(0, 0, 0); #1;
    chk("rstq_empty_we3", 64'(we3), 0);
    chk("rstq_empty_mask", 64'(pending_mask), 0);
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = $urandom_range(0, 99) == 0;
      pipe($urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)), $urandom);
      mc($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom);
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
